handshake_fifo: RTL

- Elastic buffer stage placed directly downstream of the arf dataflow block, between an arf output port (dout_req_N/dout_ack_N/dout_N) and its consumer.
- Upstream it behaves like a consumer: drives req, receives an ack pulse plus data.
- Downstream it behaves like a producer: receives req, returns a one-cycle ack pulse with registered data.
- Decouples consumer stalls (fail_rate) from the graph so arf throughput is not throttled by a bursty consumer.

---
 rtl/handshake_fifo_pkg.sv | 12 +
 rtl/handshake_fifo_if.sv | 39 +++
 rtl/handshake_fifo_mem.sv | 28 ++
 rtl/handshake_fifo.sv | 90 +++++++++
 4 files changed

// File: rtl/handshake_fifo_pkg.sv
// Shared defaults and helpers for the handshake FIFO slice.
package handshake_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 2;

  // Number of storage words for a given pointer width.
  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/handshake_fifo_if.sv
// Bundles the upstream (req_l/ack_l/din) and downstream (req_r/ack_r/dout)
// handshakes plus status. The FIFO is the slave; its environment is the master.
interface handshake_fifo_if import handshake_fifo_pkg::*; #(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int depth_log2 = DEFAULT_DEPTH_LOG2
);

  logic                  req_l;
  logic                  ack_l;
  logic [data_width-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [data_width-1:0] dout;
  logic [depth_log2:0]   level;
  logic                  overflow;

  modport slave (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout,
    output level,
    output overflow
  );

  modport master (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout,
    input  level,
    input  overflow
  );

endinterface

// File: rtl/handshake_fifo_mem.sv
// Storage for the handshake FIFO: synchronous write, combinational read.
// No reset: contents are meaningless until the pointers say otherwise.
module handshake_fifo_mem #(
  parameter int data_width = 32,
  parameter int depth_log2 = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [depth_log2-1:0] i_waddr,
  input  logic [data_width-1:0] i_wdata,
  input  logic [depth_log2-1:0] i_raddr,
  output logic [data_width-1:0] o_rdata
);

  logic [data_width-1:0] r_mem [1 << depth_log2];

  // Write the addressed word on an accepted push.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-before-write: a same-edge write to raddr is seen only next cycle,
  // which is what lets a full FIFO pop and push in one edge.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer between an arf output port and its consumer. Acts as a
// consumer upstream (req_l out, ack_l/din in) and as a producer downstream
// (req_r in, one-cycle ack_r pulse with registered dout).
module handshake_fifo import handshake_fifo_pkg::*; #(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int depth_log2 = DEFAULT_DEPTH_LOG2
) (
  input logic             clk,
  input logic             rst,
  handshake_fifo_if.slave hs
);

  localparam int                DEPTH      = fifo_depth(depth_log2);
  localparam int                LVL_W      = depth_log2 + 1;
  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(DEPTH);

  logic [depth_log2-1:0] r_wr_ptr;
  logic [depth_log2-1:0] r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_req_l;
  logic                  r_ack_r;
  logic [data_width-1:0] r_dout;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [LVL_W-1:0]      w_level_next;
  logic                  w_req_l_next;
  logic [data_width-1:0] w_rdata;

  // Pop needs a request, a non-empty store and no ack in the previous cycle,
  // so ack_r can never be high two cycles running. A push is accepted when
  // there is room, or when a same-edge pop frees the slot it lands in.
  always_comb begin
    w_full       = (r_level == FULL_LEVEL);
    w_pop        = hs.req_r & ~r_ack_r & (r_level != '0);
    w_push       = hs.ack_l & (~w_full | w_pop);
    w_drop       = hs.ack_l & ~w_push;
    w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    // Dropping req_l for the cycle after every ack keeps at most one ack
    // outstanding, so a compliant upstream can never overflow us.
    w_req_l_next = ~hs.ack_l & (w_level_next < FULL_LEVEL);
  end

  handshake_fifo_mem #(
    .data_width (data_width),
    .depth_log2 (depth_log2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (hs.din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers, occupancy, handshake outputs and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_req_l    <= 1'b0;
      r_ack_r    <= 1'b0;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + depth_log2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + depth_log2'(1);
        r_dout   <= w_rdata;
      end
      r_ack_r    <= w_pop;
      r_level    <= w_level_next;
      r_req_l    <= w_req_l_next;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign hs.req_l    = r_req_l;
  assign hs.ack_r    = r_ack_r;
  assign hs.dout     = r_dout;
  assign hs.level    = r_level;
  assign hs.overflow = r_overflow;

endmodule
